// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch prediction path (fetch BTB and execute-side resolve).
package bp_pkg;

  localparam int unsigned INSN_BYTES = 4;
  localparam int unsigned PC_BITS    = 20;

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic               taken;
    logic [PC_BITS-1:0] target;
  } bp_pred_t;

  // Fall-through PC; wraps modulo 2^PC_BITS.
  function automatic logic [PC_BITS-1:0] next_seq_pc(input logic [PC_BITS-1:0] pc);
    return pc + PC_BITS'(INSN_BYTES);
  endfunction

endpackage

// File: rtl/pred_fifo.sv
// In-order circular buffer of fetch-time predictions awaiting resolution in EX.
module pred_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic           clear,
  input  bp_pred_t       din,
  output bp_pred_t       head,
  output logic           full,
  output logic           empty,
  output logic [PTR:0]   count
);

  bp_pred_t         mem_q [DEPTH];
  logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR:0]     count_q, count_d;

  // Clear wins over push/pop; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR+1)'(1);
        2'b01:   count_d = count_q - (PTR+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/branch_resolve_unit.sv
// Checks fetch-time predictions against EX outcomes, raises flush/redirect on mispredict,
// drives the BTB update strobe and keeps saturating branch statistics.
module branch_resolve_unit #(
  parameter int unsigned PC_BITS  = bp_pkg::PC_BITS,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned PTR      = 2,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                F_valid,
  input  logic [PC_BITS-1:0]  F_pc,
  input  logic                F_BP_taken,
  input  logic [PC_BITS-1:0]  F_BP_target_pc,
  input  logic                EX_valid,
  input  logic                EX_brn,
  input  logic [PC_BITS-1:0]  EX_pc,
  input  logic                EX_true_taken,
  input  logic [PC_BITS-1:0]  EX_alu_out,
  output logic                q_full,
  output logic                BP_upd_en,
  output logic                flush,
  output logic [PC_BITS-1:0]  redirect_pc,
  output logic [CNT_BITS-1:0] br_count,
  output logic [CNT_BITS-1:0] mis_count,
  output logic                err
);

  import bp_pkg::*;

  bp_pred_t           head, push_ent;
  logic               full, empty;
  logic [PTR:0]       count;
  logic               pop, push, mispredict_now, err_now;
  logic [PC_BITS-1:0] actual_pc, predicted_pc;

  logic                flush_q, flush_d;
  logic [PC_BITS-1:0]  redirect_q, redirect_d;
  logic [CNT_BITS-1:0] br_q, br_d, mis_q, mis_d;
  logic                err_q, err_d;

  pred_fifo #(.DEPTH(DEPTH), .PTR(PTR)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (mispredict_now),
    .din   (push_ent),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Resolution: compare the actual next PC with what fetch assumed for the head entry.
  always_comb begin
    push_ent       = '{pc: F_pc, taken: F_BP_taken, target: F_BP_target_pc};
    pop            = EX_valid && !empty;
    actual_pc      = (EX_brn && EX_true_taken) ? EX_alu_out : next_seq_pc(EX_pc);
    predicted_pc   = head.taken ? head.target : next_seq_pc(head.pc);
    mispredict_now = pop && (actual_pc != predicted_pc);
    push           = F_valid && (!full || pop) && !mispredict_now && !flush_q;
    err_now        = (EX_valid && (count == '0)) || (pop && (head.pc != EX_pc));
  end

  always_comb begin
    flush_d    = mispredict_now;
    redirect_d = redirect_q;
    br_d       = br_q;
    mis_d      = mis_q;
    err_d      = err_q || err_now;
    if (mispredict_now) redirect_d = actual_pc;
    if (pop && EX_brn && (br_q != '1)) br_d = br_q + CNT_BITS'(1);
    if (mispredict_now && EX_brn && (mis_q != '1)) mis_d = mis_q + CNT_BITS'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      br_q       <= '0;
      mis_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      br_q       <= br_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
    end
  end

  assign q_full      = full;
  assign BP_upd_en   = EX_valid && EX_brn && !empty;
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign br_count    = br_q;
  assign mis_count   = mis_q;
  assign err         = err_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic against a queue-based model.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_valid, F_BP_taken, EX_valid, EX_brn, EX_true_taken;
  logic [19:0] F_pc, F_BP_target_pc, EX_pc, EX_alu_out;

  logic        q_full, BP_upd_en, flush, err;
  logic [19:0] redirect_pc;
  logic [15:0] br_count, mis_count;

  logic        q_full4, BP_upd_en4, flush4, err4;
  logic [19:0] redirect_pc4;
  logic [3:0]  br_count4, mis_count4;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [19:0] pc;
    logic        taken;
    logic [19:0] target;
  } ent_t;

  ent_t        mq[$];
  int          m_br, m_mis;
  logic        m_flush, m_err;
  logic [19:0] m_redir;

  always #5 clk = ~clk;

  branch_resolve_unit #(.PC_BITS(20), .DEPTH(4), .PTR(2), .CNT_BITS(16)) u_dut (
    .clk(clk), .rst(rst),
    .F_valid(F_valid), .F_pc(F_pc), .F_BP_taken(F_BP_taken), .F_BP_target_pc(F_BP_target_pc),
    .EX_valid(EX_valid), .EX_brn(EX_brn), .EX_pc(EX_pc), .EX_true_taken(EX_true_taken),
    .EX_alu_out(EX_alu_out),
    .q_full(q_full), .BP_upd_en(BP_upd_en), .flush(flush), .redirect_pc(redirect_pc),
    .br_count(br_count), .mis_count(mis_count), .err(err)
  );

  branch_resolve_unit #(.PC_BITS(20), .DEPTH(4), .PTR(2), .CNT_BITS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .F_valid(F_valid), .F_pc(F_pc), .F_BP_taken(F_BP_taken), .F_BP_target_pc(F_BP_target_pc),
    .EX_valid(EX_valid), .EX_brn(EX_brn), .EX_pc(EX_pc), .EX_true_taken(EX_true_taken),
    .EX_alu_out(EX_alu_out),
    .q_full(q_full4), .BP_upd_en(BP_upd_en4), .flush(flush4), .redirect_pc(redirect_pc4),
    .br_count(br_count4), .mis_count(mis_count4), .err(err4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic check_outputs();
    check("q_full",      32'(q_full),      32'(mq.size() == 4));
    check("flush",       32'(flush),       32'(m_flush));
    check("redirect_pc", 32'(redirect_pc), 32'(m_redir));
    check("br_count",    32'(br_count),    32'(sat(m_br, 65535)));
    check("mis_count",   32'(mis_count),   32'(sat(m_mis, 65535)));
    check("err",         32'(err),         32'(m_err));
    check("br_count4",   32'(br_count4),   32'(sat(m_br, 15)));
    check("mis_count4",  32'(mis_count4),  32'(sat(m_mis, 15)));
  endtask

  task automatic model_reset();
    mq.delete();
    m_br    = 0;
    m_mis   = 0;
    m_flush = 1'b0;
    m_err   = 1'b0;
    m_redir = '0;
  endtask

  task automatic zero_inputs();
    F_valid = 0; F_pc = '0; F_BP_taken = 0; F_BP_target_pc = '0;
    EX_valid = 0; EX_brn = 0; EX_pc = '0; EX_true_taken = 0; EX_alu_out = '0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    @(posedge clk);
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle: drive inputs, advance the model by the operational rules, check after the edge.
  task automatic step(input bit fv, input logic [19:0] fpc, input bit ft, input logic [19:0] ftgt,
                      input bit exv, input bit brn, input logic [19:0] expc, input bit tt,
                      input logic [19:0] alu);
    bit          pop, push, mis;
    logic [19:0] act, pred;
    F_valid = fv; F_pc = fpc; F_BP_taken = ft; F_BP_target_pc = ftgt;
    EX_valid = exv; EX_brn = brn; EX_pc = expc; EX_true_taken = tt; EX_alu_out = alu;
    #1;
    check("bp_upd_en", 32'(BP_upd_en), 32'(exv && brn && (mq.size() != 0)));
    pop  = exv && (mq.size() != 0);
    mis  = 1'b0;
    if (exv && mq.size() == 0) m_err = 1'b1;
    if (pop) begin
      if (mq[0].pc != expc) m_err = 1'b1;
      act  = (brn && tt) ? alu : expc + 20'd4;
      pred = mq[0].taken ? mq[0].target : mq[0].pc + 20'd4;
      mis  = (act != pred);
      if (brn) m_br++;
      if (mis && brn) m_mis++;
      if (mis) m_redir = act;
    end
    push = fv && ((mq.size() < 4) || pop) && !mis && !m_flush;
    if (pop) void'(mq.pop_front());
    if (mis) mq.delete();
    else if (push) mq.push_back('{pc: fpc, taken: ft, target: ftgt});
    m_flush = mis;
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, 0, '0, 0, '0);
  endtask

  bit          r_fv, r_ft, r_exv, r_brn, r_tt;
  logic [19:0] r_fpc, r_ftgt, r_expc, r_alu;

  initial begin
    model_reset();
    zero_inputs();
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Fill to DEPTH, drop a fifth push, then drain with matching outcomes.
    for (int i = 0; i < 4; i++) step(1, 20'(i * 4), 0, '0, 0, 0, '0, 0, '0);
    check("full_after_4", 32'(q_full), 32'd1);
    step(1, 20'h10, 0, '0, 0, 0, '0, 0, '0);
    for (int i = 0; i < 4; i++) step(0, '0, 0, '0, 1, 0, 20'(i * 4), 0, '0);
    check("drain_no_flush", 32'(flush), 32'd0);
    check("drain_not_full", 32'(q_full), 32'd0);
    check("drain_no_err", 32'(err), 32'd0);

    // Predicted not-taken, resolves taken.
    step(1, 20'h100, 0, '0, 0, 0, '0, 0, '0);
    step(0, '0, 0, '0, 1, 1, 20'h100, 1, 20'h200);
    check("nt_to_t_flush", 32'(flush), 32'd1);
    check("nt_to_t_redirect", 32'(redirect_pc), 32'h200);
    check("nt_to_t_mis", 32'(mis_count), 32'd1);
    idle();
    check("flush_one_cycle", 32'(flush), 32'd0);
    check("redirect_held", 32'(redirect_pc), 32'h200);

    // Predicted taken, resolves not-taken; the push in the flush cycle is wrong-path.
    step(1, 20'h104, 1, 20'h300, 0, 0, '0, 0, '0);
    step(0, '0, 0, '0, 1, 1, 20'h104, 0, 20'h300);
    check("t_to_nt_redirect", 32'(redirect_pc), 32'h108);
    check("t_to_nt_br", 32'(br_count), 32'd2);
    step(1, 20'h500, 0, '0, 0, 0, '0, 0, '0);

    // Taken prediction aliased onto a non-branch.
    step(1, 20'h40, 1, 20'h80, 0, 0, '0, 0, '0);
    step(0, '0, 0, '0, 1, 0, 20'h40, 0, 20'h0);
    check("alias_flush", 32'(flush), 32'd1);
    check("alias_redirect", 32'(redirect_pc), 32'h44);
    check("alias_mis_same", 32'(mis_count), 32'd2);
    check("alias_no_err", 32'(err), 32'd0);
    idle();

    // PC wrap at the top of the address space.
    step(1, 20'hFFFFC, 0, '0, 0, 0, '0, 0, '0);
    step(0, '0, 0, '0, 1, 1, 20'hFFFFC, 0, 20'h1234);
    check("wrap_no_flush", 32'(flush), 32'd0);

    // Head PC mismatch.
    step(1, 20'h10, 0, '0, 0, 0, '0, 0, '0);
    step(0, '0, 0, '0, 1, 0, 20'h14, 0, '0);
    check("err_pc_mismatch", 32'(err), 32'd1);
    idle();
    do_reset();
    check("err_cleared", 32'(err), 32'd0);

    // Resolve with an empty queue: sticky error.
    step(0, '0, 0, '0, 1, 1, 20'h20, 1, 20'h80);
    check("err_empty_pop", 32'(err), 32'd1);
    check("empty_pop_no_flush", 32'(flush), 32'd0);
    for (int i = 0; i < 3; i++) idle();
    check("err_sticky", 32'(err), 32'd1);
    do_reset();

    // Saturation: 20 correctly predicted branches.
    step(1, 20'h0, 0, '0, 0, 0, '0, 0, '0);
    for (int i = 0; i < 20; i++)
      step(1, 20'((i + 1) * 4), 0, '0, 1, 1, 20'(i * 4), 0, 20'h3C0);
    check("sat_br16", 32'(br_count), 32'd20);
    check("sat_br4", 32'(br_count4), 32'd15);
    check("sat_no_mis", 32'(mis_count), 32'd0);

    // Random traffic with occasional mid-operation resets.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        r_fv   = ($urandom_range(0, 3) != 0);
        r_fpc  = ($urandom_range(0, 7) == 0) ? 20'hFFFFC : 20'($urandom) & 20'hFFFFC;
        r_ft   = $urandom_range(0, 1) == 1;
        r_ftgt = 20'($urandom) & 20'hFFFFC;
        r_brn  = $urandom_range(0, 1) == 1;
        r_tt   = $urandom_range(0, 1) == 1;
        r_alu  = 20'($urandom) & 20'hFFFFC;
        r_expc = 20'($urandom) & 20'hFFFFC;
        if (mq.size() != 0) begin
          r_exv = $urandom_range(0, 1) == 1;
          if ($urandom_range(0, 99) != 0) r_expc = mq[0].pc;
          if ($urandom_range(0, 3) != 0) begin
            if (mq[0].taken) begin
              r_brn = 1'b1; r_tt = 1'b1; r_alu = mq[0].target;
            end else begin
              r_tt = 1'b0;
            end
          end
        end else begin
          r_exv = ($urandom_range(0, 49) == 0);
        end
        step(r_fv, r_fpc, r_ft, r_ftgt, r_exv, r_brn, r_expc, r_tt, r_alu);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-side counterpart of the fetch-stage branch target buffer: records every prediction made at fetch in a small in-order queue, checks each against the resolved outcome when the instruction leaves EX, and raises a one-cycle flush with the corrected PC on any mismatch. It also drives the BTB update strobe and keeps branch and mispredict statistics.

## Interface
- PC_BITS, 20, PC width (byte address, word-aligned)
- DEPTH, 4, max predictions in flight between F and EX (power of 2)
- PTR, 2, log2(DEPTH)
- CNT_BITS, 16, statistics counter width
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- F_valid  in  1  instruction leaves F this cycle (fetch not stalled)
- F_pc  in  PC_BITS  its PC
- F_BP_taken  in  1  prediction: taken
- F_BP_target_pc  in  PC_BITS  prediction: next PC
- EX_valid  in  1  instruction leaves EX this cycle
- EX_brn  in  1  that instruction is a branch
- EX_pc  in  PC_BITS  its PC
- EX_true_taken  in  1  resolved direction
- EX_alu_out  in  PC_BITS  resolved target
- q_full  out  1  queue holds DEPTH entries; fetch must stall
- BP_upd_en  out  1  combinational: EX_valid && EX_brn && queue non-empty
- flush  out  1  registered one-cycle pulse: squash F..EX
- redirect_pc  out  PC_BITS  registered corrected PC, valid while flush=1
- br_count, mis_count  out  CNT_BITS each  resolved branches / mispredicts, saturating
- err  out  1  sticky: pop on empty, or head PC != EX_pc

## Operation
- Entry = {pc, pred_taken, pred_target}. Push at F, pop at EX, strictly in order.
- Push accepted when F_valid && (!q_full || pop this cycle) && !mispredict_now && !flush. Otherwise dropped.
- Pop when EX_valid && count != 0. When EX_valid && count == 0: set err, no other effect.
- Sequential PC = pc + 4, modulo 2^PC_BITS.
- Actual next PC = (EX_brn && EX_true_taken) ? EX_alu_out : EX_pc + 4.
- Predicted next PC = head.pred_taken ? head.pred_target : head.pc + 4.
- mispredict_now = pop && (actual != predicted). This also catches a taken prediction on a non-branch (aliasing): redirect to EX_pc + 4.
- Head PC != EX_pc on a pop: set err. Compare using EX_pc regardless.
- On mispredict_now, at the clock edge:
  - Clear the queue (count=0, pointers=0).
  - flush<=1, redirect_pc<=actual.
  - On EX_brn, mis_count++.
- br_count++ on every pop with EX_brn.
- Both counters hold at all-ones.
- flush lasts exactly one cycle. Pushes during the flush cycle are dropped; they are wrong-path.

## Timing
- Reset values: q_full=0, flush=0, redirect_pc=0, br_count=0, mis_count=0, err=0, queue empty, pointers 0.
- Reset mid-operation discards all entries.
- Resolution-to-flush latency: 1 cycle. redirect_pc changes only on the mispredict edge.
- Entry pushed at edge N is poppable from cycle N+1.
- Simultaneous push+pop at full without mispredict: both occur, count stays DEPTH.
- Simultaneous push+pop with mispredict: queue ends empty.
- Pointers wrap modulo DEPTH. count is PTR+1 bits wide.

## Structure
- Shared package bp_pkg:
  - INSN_BYTES=4, default PC_BITS.
  - bp_pred_t struct {pc, taken, target}.
  - Function next_seq_pc.
- Sub-module pred_fifo: DEPTH-entry circular buffer of bp_pred_t.
  - Ports: push, pop, clear, head, full, empty, count.
- Compare, flush register and counters live in the top level.

## Test plan
- Reset, then push 4 entries with no pop -> q_full=1. A 5th push is dropped. Pop 4 with matching outcomes -> no flush, empty.
- Predicted not-taken at pc 0x100, branch resolves taken to 0x200 -> next cycle flush=1, redirect_pc=0x200, mis_count=1, queue empty.
- Predicted taken to 0x300 at pc 0x104, resolves not-taken -> flush, redirect_pc=0x108. Br_count increments.
- Non-branch at 0x40 with F_BP_taken=1 -> flush, redirect_pc=0x44, mis_count unchanged.
- Wrap case: push at pc 0xFFFFC, predicted not-taken; resolves not-taken -> expected 0x00000, no flush.
- EX_valid with queue empty -> err=1, stays 1 until rst. Mismatched head PC also sets err.
- Counter saturation (CNT_BITS=4 build): 20 branches -> br_count=15.
